// File: rtl/pc_seq_pkg.sv
// Shared types and defaults for the fetch-stage PC sequencer.
package pc_seq_pkg;

    typedef enum logic {
        RUN,
        HAZ
    } state_t;

    typedef enum logic [1:0] {
        NONE,
        EXC,
        BR,
        JMP
    } redir_t;

    localparam logic [31:0] DEF_EXC_VECTOR = 32'h0000_0040;

endpackage

// File: rtl/pc_sequencer_if.sv
// Request/response bundle between the pipeline and the PC sequencer.
interface pc_sequencer_if #(
    parameter int AW = 32,
    parameter int CW = 16
);
    logic          exc_req;
    logic          br_taken;
    logic [AW-1:0] br_target;
    logic          jmp_req;
    logic [AW-1:0] jmp_target;
    logic          load_use;
    logic          imem_ready;
    logic          Stall;
    logic          PCsrc;
    logic [AW-1:0] inMux;
    logic          flush_ifid;
    logic          flush_idex;
    logic [CW-1:0] stall_cnt;
    logic [CW-1:0] redir_cnt;
    logic          imem_timeout;

    modport master (
        output exc_req, br_taken, br_target, jmp_req, jmp_target, load_use, imem_ready,
        input  Stall, PCsrc, inMux, flush_ifid, flush_idex, stall_cnt, redir_cnt, imem_timeout
    );

    modport slave (
        input  exc_req, br_taken, br_target, jmp_req, jmp_target, load_use, imem_ready,
        output Stall, PCsrc, inMux, flush_ifid, flush_idex, stall_cnt, redir_cnt, imem_timeout
    );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter used for the stall and redirect performance counters.
module sat_counter #(
    parameter int CW = 16
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          inc,
    output logic [CW-1:0] count
);

    // Count up on inc, holding at all-ones instead of wrapping.
    always_ff @(posedge CLK) begin
        if (RST) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage PC control: arbitrates redirects, load-use bubbles and imem waits
// into a Stall/PCsrc/inMux triple plus pipeline flush strobes.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int            AW           = 32,
    parameter logic [AW-1:0] EXC_VECTOR   = AW'(DEF_EXC_VECTOR),
    parameter int            LU_CYCLES    = 1,
    parameter int            CW           = 16,
    parameter int            IMEM_TIMEOUT = 255
) (
    input logic           CLK,
    input logic           RST,
    pc_sequencer_if.slave bus
);

    state_t        state, state_d;
    logic [2:0]    hz_cnt, hz_d;
    logic          lu_pend, lu_pend_d;
    logic [8:0]    wait_cnt, wait_d;
    logic          timeout_q;
    redir_t        src;

    logic          stall, pcsrc, flush_ifid, flush_idex;
    logic [AW-1:0] inmux;
    logic [CW-1:0] stall_cnt_q, redir_cnt_q;

    // Redirect source selection: exception beats branch beats jump.
    always_comb begin
        src = NONE;
        if (bus.exc_req)       src = EXC;
        else if (bus.br_taken) src = BR;
        else if (bus.jmp_req)  src = JMP;
    end

    // State register plus imem wait counter and sticky timeout flag.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= RUN;
            hz_cnt    <= '0;
            lu_pend   <= 1'b0;
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            state    <= state_d;
            hz_cnt   <= hz_d;
            lu_pend  <= lu_pend_d;
            wait_cnt <= wait_d;
            if (wait_d == 9'(IMEM_TIMEOUT)) timeout_q <= 1'b1;
        end
    end

    // Next-state logic; an imem wait freezes the bubble sequence, a redirect aborts it.
    always_comb begin
        state_d   = state;
        hz_d      = hz_cnt;
        lu_pend_d = lu_pend;
        wait_d    = '0;
        if (!bus.imem_ready) begin
            wait_d = (wait_cnt == '1) ? wait_cnt : wait_cnt + 9'd1;
        end
        if (src != NONE) begin
            state_d   = RUN;
            hz_d      = '0;
            lu_pend_d = 1'b0;
        end else if (!bus.imem_ready) begin
            // A hazard seen during an imem wait is parked until data arrives.
            if (state == RUN && bus.load_use) lu_pend_d = 1'b1;
        end else if (state == HAZ) begin
            if (hz_cnt == 3'd1) begin
                state_d = RUN;
                hz_d    = '0;
            end else begin
                hz_d = hz_cnt - 3'd1;
            end
        end else if (lu_pend || bus.load_use) begin
            lu_pend_d = 1'b0;
            if (LU_CYCLES > 1) begin
                state_d = HAZ;
                hz_d    = 3'(LU_CYCLES - 1);
            end
        end
    end

    // Output decode, forced to zero while reset is asserted.
    always_comb begin
        stall      = 1'b0;
        pcsrc      = 1'b0;
        inmux      = '0;
        flush_ifid = 1'b0;
        flush_idex = 1'b0;
        if (!RST) begin
            case (src)
                EXC: begin
                    pcsrc      = 1'b1;
                    inmux      = EXC_VECTOR;
                    flush_ifid = 1'b1;
                    flush_idex = 1'b1;
                end
                BR: begin
                    pcsrc      = 1'b1;
                    inmux      = bus.br_target;
                    flush_ifid = 1'b1;
                    flush_idex = 1'b1;
                end
                JMP: begin
                    pcsrc      = 1'b1;
                    inmux      = bus.jmp_target;
                    flush_ifid = 1'b1;
                end
                default: begin
                    if (!bus.imem_ready) begin
                        stall = 1'b1;
                        // Bubble is inserted only on the cycle the hazard first appears.
                        if (state == RUN && bus.load_use && !lu_pend) flush_idex = 1'b1;
                    end else if (state == HAZ) begin
                        stall      = 1'b1;
                        flush_idex = 1'b1;
                    end else if (lu_pend) begin
                        stall = 1'b1;
                    end else if (bus.load_use) begin
                        stall      = 1'b1;
                        flush_idex = 1'b1;
                    end
                end
            endcase
        end
    end

    sat_counter #(.CW(CW)) u_stall_cnt (
        .CLK   (CLK),
        .RST   (RST),
        .inc   (stall),
        .count (stall_cnt_q)
    );

    sat_counter #(.CW(CW)) u_redir_cnt (
        .CLK   (CLK),
        .RST   (RST),
        .inc   (pcsrc),
        .count (redir_cnt_q)
    );

    assign bus.Stall        = stall;
    assign bus.PCsrc        = pcsrc;
    assign bus.inMux        = inmux;
    assign bus.flush_ifid   = flush_ifid;
    assign bus.flush_idex   = flush_idex;
    assign bus.stall_cnt    = RST ? '0 : stall_cnt_q;
    assign bus.redir_cnt    = RST ? '0 : redir_cnt_q;
    assign bus.imem_timeout = timeout_q & ~RST;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer: one instance with LU_CYCLES=3/CW=16
// and one with LU_CYCLES=1/CW=4, both fed the same stimulus.
module tb_pc_sequencer;

    logic        CLK = 1'b0;
    logic        RST;
    logic        exc_req, br_taken, jmp_req, load_use, imem_ready;
    logic [31:0] br_target, jmp_target;
    int          n_pass  = 0;
    int          n_total = 0;
    int          n_fail  = 0;

    always #5 CLK = ~CLK;

    pc_sequencer_if #(.AW(32), .CW(16)) if3 ();
    pc_sequencer_if #(.AW(32), .CW(4))  if1 ();

    assign if3.exc_req    = exc_req;
    assign if3.br_taken   = br_taken;
    assign if3.br_target  = br_target;
    assign if3.jmp_req    = jmp_req;
    assign if3.jmp_target = jmp_target;
    assign if3.load_use   = load_use;
    assign if3.imem_ready = imem_ready;
    assign if1.exc_req    = exc_req;
    assign if1.br_taken   = br_taken;
    assign if1.br_target  = br_target;
    assign if1.jmp_req    = jmp_req;
    assign if1.jmp_target = jmp_target;
    assign if1.load_use   = load_use;
    assign if1.imem_ready = imem_ready;

    pc_sequencer #(.AW(32), .LU_CYCLES(3), .CW(16), .IMEM_TIMEOUT(255)) dut3 (
        .CLK (CLK),
        .RST (RST),
        .bus (if3.slave)
    );

    pc_sequencer #(.AW(32), .LU_CYCLES(1), .CW(4), .IMEM_TIMEOUT(255)) dut1 (
        .CLK (CLK),
        .RST (RST),
        .bus (if1.slave)
    );

    function automatic void chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST = 1'b1; exc_req = 1'b1; br_taken = 1'b0; jmp_req = 1'b0;
        load_use = 1'b1; imem_ready = 1'b1; br_target = '0; jmp_target = '0;
        #1;
        // Reset gates outputs even with requests present.
        chk("rst_stall", 32'(if3.Stall), 32'd0);
        chk("rst_pcsrc", 32'(if3.PCsrc), 32'd0);
        chk("rst_inmux", if3.inMux, 32'd0);
        chk("rst_flush", 32'({if3.flush_ifid, if3.flush_idex}), 32'd0);
        tick();
        chk("rst2_pcsrc", 32'(if3.PCsrc), 32'd0);
        tick();
        RST = 1'b0; exc_req = 1'b0; load_use = 1'b0;
        #1;
        for (int i = 0; i < 10; i++) begin
            chk("idle_stall_pcsrc", 32'({if3.Stall, if3.PCsrc}), 32'd0);
            tick();
        end
        chk("idle_stall_cnt", 32'(if3.stall_cnt), 32'd0);
        chk("idle_redir_cnt", 32'(if3.redir_cnt), 32'd0);

        // Load-use with LU_CYCLES=3; re-assertion in HAZ is ignored.
        load_use = 1'b1; #1;
        chk("lu_c0", 32'({if3.Stall, if3.flush_idex, if3.flush_ifid}), 32'b110);
        tick();
        #1;
        chk("lu_c1", 32'({if3.Stall, if3.flush_idex}), 32'b11);
        tick();
        load_use = 1'b0; #1;
        chk("lu_c2", 32'({if3.Stall, if3.flush_idex}), 32'b11);
        tick();
        #1;
        chk("lu_done", 32'({if3.Stall, if3.flush_idex}), 32'b00);
        chk("lu_stall_cnt", 32'(if3.stall_cnt), 32'd3);

        // Branch beats jump.
        br_taken = 1'b1; br_target = 32'h100; jmp_req = 1'b1; jmp_target = 32'h200; #1;
        chk("br_pcsrc_stall", 32'({if3.PCsrc, if3.Stall}), 32'b10);
        chk("br_inmux", if3.inMux, 32'h100);
        chk("br_flush", 32'({if3.flush_ifid, if3.flush_idex}), 32'b11);
        tick();
        br_taken = 1'b0; #1;
        chk("br_redir_cnt", 32'(if3.redir_cnt), 32'd1);
        chk("jmp_inmux", if3.inMux, 32'h200);
        chk("jmp_flush", 32'({if3.flush_ifid, if3.flush_idex}), 32'b10);
        tick();
        jmp_req = 1'b0; exc_req = 1'b1; imem_ready = 1'b0; #1;
        chk("exc_wait_stall", 32'({if3.PCsrc, if3.Stall}), 32'b10);
        chk("exc_inmux", if3.inMux, 32'h40);
        tick();
        exc_req = 1'b0; imem_ready = 1'b1; #1;
        chk("redir_cnt3", 32'(if3.redir_cnt), 32'd3);

        // Exception aborts a HAZ sequence at hz_cnt=2.
        load_use = 1'b1; #1;
        tick();
        load_use = 1'b0; exc_req = 1'b1; #1;
        chk("haz_exc_inmux", if3.inMux, 32'h40);
        chk("haz_exc_stall", 32'({if3.Stall, if3.PCsrc}), 32'b01);
        tick();
        exc_req = 1'b0; #1;
        chk("haz_exc_run", 32'(if3.Stall), 32'd0);
        tick();

        // imem wait freezes HAZ countdown.
        load_use = 1'b1; #1;
        tick();
        load_use = 1'b0; imem_ready = 1'b0; #1;
        chk("haz_frz0", 32'({if3.Stall, if3.flush_idex, if3.flush_ifid}), 32'b100);
        tick();
        #1;
        chk("haz_frz1", 32'({if3.Stall, if3.flush_idex}), 32'b10);
        tick();
        imem_ready = 1'b1; #1;
        chk("haz_res2", 32'({if3.Stall, if3.flush_idex}), 32'b11);
        tick();
        #1;
        chk("haz_res1", 32'({if3.Stall, if3.flush_idex}), 32'b11);
        tick();
        #1;
        chk("haz_res_run", 32'(if3.Stall), 32'd0);

        // LU_CYCLES=1: load-use coincident with 4 imem-wait cycles.
        load_use = 1'b1; imem_ready = 1'b0; #1;
        chk("luw_c0", 32'({if1.Stall, if1.flush_idex}), 32'b11);
        for (int i = 1; i < 4; i++) begin
            tick();
            #1;
            chk("luw_wait", 32'({if1.Stall, if1.flush_idex}), 32'b10);
        end
        tick();
        load_use = 1'b0; imem_ready = 1'b1; #1;
        chk("luw_bubble", 32'({if1.Stall, if1.flush_idex}), 32'b10);
        tick();
        #1;
        chk("luw_done", 32'(if1.Stall), 32'd0);
        repeat (3) tick();

        // Timeout and counter saturation.
        RST = 1'b1;
        tick();
        RST = 1'b0; imem_ready = 1'b0;
        repeat (254) tick();
        chk("to_254", 32'(if1.imem_timeout), 32'd0);
        tick();
        chk("to_255", 32'(if1.imem_timeout), 32'd1);
        chk("to_255_d3", 32'(if3.imem_timeout), 32'd1);
        repeat (45) tick();
        imem_ready = 1'b1; #1;
        tick();
        chk("to_sticky", 32'(if1.imem_timeout), 32'd1);
        chk("sat_cnt4", 32'(if1.stall_cnt), 32'd15);
        chk("cnt16_300", 32'(if3.stall_cnt), 32'd300);
        RST = 1'b1; #1;
        chk("to_rst_gate", 32'(if1.imem_timeout), 32'd0);
        chk("cnt_rst_gate", 32'(if1.stall_cnt), 32'd0);
        tick();
        RST = 1'b0; #1;
        chk("to_cleared", 32'(if1.imem_timeout), 32'd0);
        chk("cnt_cleared", 32'(if3.stall_cnt), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
